// File: rtl/pe_conv1d.sv
// pe_conv1d: single 1-D convolution processing element.
// Holds a filter and an ifmap scratchpad loaded over addressed write
// channels. A start token runs every valid sliding-window dot product,
// each added to an incoming partial sum, emits them in order on psum_out,
// and ends the run with a done token.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   filter_addr_* / filter_in_*  paired filter write channels (addr + data)
//   ifmap_addr_*  / ifmap_in_*   paired ifmap write channels (addr + data)
//   start_valid/ready        run trigger token
//   psum_in_valid/ready      incoming partial sum, one per output
//   psum_out_valid/ready     result partial sums
//   done_valid/ready         end-of-run token
//
// Build option: define PE_PSUM_SAT_EN to saturate each accumulate step at
// 2^WIDTH-1; otherwise accumulation wraps modulo 2^WIDTH.
module pe_conv1d #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH_I = 5,
  parameter int unsigned ADDR_I  = 3,
  parameter int unsigned DEPTH_F = 3,
  parameter int unsigned ADDR_F  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               filter_addr_valid,
  output logic               filter_addr_ready,
  input  logic [ADDR_F-1:0]  filter_addr,
  input  logic               filter_in_valid,
  output logic               filter_in_ready,
  input  logic [WIDTH/2-1:0] filter_in,
  input  logic               ifmap_addr_valid,
  output logic               ifmap_addr_ready,
  input  logic [ADDR_I-1:0]  ifmap_addr,
  input  logic               ifmap_in_valid,
  output logic               ifmap_in_ready,
  input  logic [WIDTH/2-1:0] ifmap_in,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic               psum_in_valid,
  output logic               psum_in_ready,
  input  logic [WIDTH-1:0]   psum_in,
  output logic               psum_out_valid,
  input  logic               psum_out_ready,
  output logic [WIDTH-1:0]   psum_out,
  output logic               done_valid,
  input  logic               done_ready
);

  localparam int unsigned EW    = WIDTH / 2;
  localparam int unsigned N_OUT = DEPTH_I - DEPTH_F + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PSUM,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    acc, acc_next;
  logic [ADDR_I-1:0]   j, j_next;
  logic [ADDR_F-1:0]   k, k_next;

  logic [EW-1:0]       filt [DEPTH_F];
  logic [EW-1:0]       ifm  [DEPTH_I];

  logic [ADDR_I-1:0]   ifm_idx;
  logic [WIDTH-1:0]    prod;
  logic [WIDTH-1:0]    mac_sum;

  // Current tap: filter[k] * ifmap[j+k], widened to the psum width
  assign ifm_idx = j + ADDR_I'(k);
  assign prod    = WIDTH'(filt[k]) * WIDTH'(ifm[ifm_idx]);

`ifdef PE_PSUM_SAT_EN
  // Extra carry bit detects overflow so the step can clamp
  logic [WIDTH:0] mac_wide;
  assign mac_wide = {1'b0, acc} + {1'b0, prod};
  assign mac_sum  = mac_wide[WIDTH] ? '1 : mac_wide[WIDTH-1:0];
`else
  assign mac_sum  = acc + prod;
`endif

  assign psum_out = acc;

  // Next-state and handshake decode; everything is gated off during reset
  always_comb begin
    state_next        = state;
    acc_next          = acc;
    j_next            = j;
    k_next            = k;
    filter_addr_ready = 1'b0;
    filter_in_ready   = 1'b0;
    ifmap_addr_ready  = 1'b0;
    ifmap_in_ready    = 1'b0;
    start_ready       = 1'b0;
    psum_in_ready     = 1'b0;
    psum_out_valid    = 1'b0;
    done_valid        = 1'b0;

    if (!rst) begin
      case (state)
        S_IDLE: begin
          // Address and data of a write channel complete together only
          filter_addr_ready = filter_addr_valid && filter_in_valid;
          filter_in_ready   = filter_addr_valid && filter_in_valid;
          ifmap_addr_ready  = ifmap_addr_valid && ifmap_in_valid;
          ifmap_in_ready    = ifmap_addr_valid && ifmap_in_valid;
          start_ready       = 1'b1;
          if (start_valid) begin
            j_next     = '0;
            state_next = S_PSUM;
          end
        end
        S_PSUM: begin
          psum_in_ready = 1'b1;
          if (psum_in_valid) begin
            acc_next   = psum_in;
            k_next     = '0;
            state_next = S_MAC;
          end
        end
        S_MAC: begin
          acc_next = mac_sum;
          k_next   = k + ADDR_F'(1);
          if (k == ADDR_F'(DEPTH_F - 1)) begin
            state_next = S_OUT;
          end
        end
        S_OUT: begin
          psum_out_valid = 1'b1;
          if (psum_out_ready) begin
            if (j == ADDR_I'(N_OUT - 1)) begin
              state_next = S_DONE;
            end else begin
              j_next     = j + ADDR_I'(1);
              state_next = S_PSUM;
            end
          end
        end
        S_DONE: begin
          done_valid = 1'b1;
          if (done_ready) begin
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Control and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      j     <= '0;
      k     <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      j     <= j_next;
      k     <= k_next;
    end
  end

  // Scratchpads; out-of-range addresses complete the handshake but drop data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH_F; i++) filt[i] <= '0;
      for (int unsigned i = 0; i < DEPTH_I; i++) ifm[i]  <= '0;
    end else begin
      if (filter_addr_ready && (32'(filter_addr) < DEPTH_F)) begin
        filt[filter_addr] <= filter_in;
      end
      if (ifmap_addr_ready && (32'(ifmap_addr) < DEPTH_I)) begin
        ifm[ifmap_addr] <= ifmap_in;
      end
    end
  end

endmodule

// File: tb/tb_pe_conv1d.sv
// Scoreboard bench for pe_conv1d: drivers push expected psums into a queue,
// a negedge monitor pops and compares on every psum_out transfer.
module tb_pe_conv1d;

  logic       clk = 1'b0;
  logic       rst;
  logic       filter_addr_valid, filter_addr_ready;
  logic [1:0] filter_addr;
  logic       filter_in_valid, filter_in_ready;
  logic [3:0] filter_in;
  logic       ifmap_addr_valid, ifmap_addr_ready;
  logic [2:0] ifmap_addr;
  logic       ifmap_in_valid, ifmap_in_ready;
  logic [3:0] ifmap_in;
  logic       start_valid, start_ready;
  logic       psum_in_valid, psum_in_ready;
  logic [7:0] psum_in;
  logic       psum_out_valid, psum_out_ready;
  logic [7:0] psum_out;
  logic       done_valid, done_ready;

  int asserts  = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int exp_done = 0;

  always #5 clk = ~clk;

  pe_conv1d dut (
    .clk(clk), .rst(rst),
    .filter_addr_valid(filter_addr_valid), .filter_addr_ready(filter_addr_ready),
    .filter_addr(filter_addr),
    .filter_in_valid(filter_in_valid), .filter_in_ready(filter_in_ready),
    .filter_in(filter_in),
    .ifmap_addr_valid(ifmap_addr_valid), .ifmap_addr_ready(ifmap_addr_ready),
    .ifmap_addr(ifmap_addr),
    .ifmap_in_valid(ifmap_in_valid), .ifmap_in_ready(ifmap_in_ready),
    .ifmap_in(ifmap_in),
    .start_valid(start_valid), .start_ready(start_ready),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
    .psum_in(psum_in),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready),
    .psum_out(psum_out),
    .done_valid(done_valid), .done_ready(done_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    asserts++;
    failures++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Monitor: compares every psum_out/done transfer against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (psum_out_valid) begin
        if (exp_q.size() == 0) begin
          asserts++;
          failures++;
          $display("FAIL psum_out_unexpected: got %0d expected no output", psum_out);
        end else if (psum_out_ready) begin
          check("psum_out", 32'(psum_out), 32'(exp_q.pop_front()));
        end else begin
          check("psum_out_held", 32'(psum_out), 32'(exp_q[0]));
        end
      end
      if (done_valid && done_ready) begin
        asserts++;
        if (exp_done == 0 || exp_q.size() != 0) begin
          failures++;
          $display("FAIL done_token: got done with %0d psums pending expected none", exp_q.size());
        end else begin
          exp_done--;
        end
      end
    end
  end

  task automatic write_f(input logic [1:0] a, input logic [3:0] d);
    int n = 0;
    filter_addr = a; filter_in = d;
    filter_addr_valid = 1'b1; filter_in_valid = 1'b1;
    do begin @(negedge clk); n++; end
    while (!(filter_addr_ready && filter_in_ready) && n < 100);
    if (!(filter_addr_ready && filter_in_ready)) timeout_fail("filter_write");
    @(posedge clk); #1;
    filter_addr_valid = 1'b0; filter_in_valid = 1'b0;
  endtask

  task automatic write_i(input logic [2:0] a, input logic [3:0] d);
    int n = 0;
    ifmap_addr = a; ifmap_in = d;
    ifmap_addr_valid = 1'b1; ifmap_in_valid = 1'b1;
    do begin @(negedge clk); n++; end
    while (!(ifmap_addr_ready && ifmap_in_ready) && n < 100);
    if (!(ifmap_addr_ready && ifmap_in_ready)) timeout_fail("ifmap_write");
    @(posedge clk); #1;
    ifmap_addr_valid = 1'b0; ifmap_in_valid = 1'b0;
  endtask

  task automatic do_start();
    int n = 0;
    start_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!start_ready && n < 100);
    if (!start_ready) timeout_fail("start");
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic send_psum(input logic [7:0] v);
    int n = 0;
    psum_in = v; psum_in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!psum_in_ready && n < 100);
    if (!psum_in_ready) timeout_fail("psum_in");
    @(posedge clk); #1;
    psum_in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_done != 0 || exp_q.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    if (exp_done != 0 || exp_q.size() != 0) timeout_fail("run_complete");
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [3:0] f0, f1, f2, i0, i1, i2, i3, i4);
    write_f(2'd0, f0); write_f(2'd1, f1); write_f(2'd2, f2);
    write_i(3'd0, i0); write_i(3'd1, i1); write_i(3'd2, i2);
    write_i(3'd3, i3); write_i(3'd4, i4);
  endtask

  task automatic run(input logic [7:0] p, input logic [7:0] e0, e1, e2);
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
    exp_done++;
    do_start();
    send_psum(p); send_psum(p); send_psum(p);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ovf;
    int n;
`ifdef PE_PSUM_SAT_EN
    ovf = 8'd255;
`else
    ovf = 8'd163;
`endif
    rst = 1'b1;
    filter_addr_valid = 0; filter_in_valid = 0; filter_addr = 0; filter_in = 0;
    ifmap_addr_valid = 0; ifmap_in_valid = 0; ifmap_addr = 0; ifmap_in = 0;
    start_valid = 0; psum_in_valid = 0; psum_in = 0;
    psum_out_ready = 1'b1; done_ready = 1'b1;
    repeat (2) @(posedge clk);
    start_valid = 1'b1; psum_in_valid = 1'b1;
    @(negedge clk);
    check("rst_start_ready", 32'(start_ready), 0);
    check("rst_psum_out_valid", 32'(psum_out_valid), 0);
    check("rst_psum_out", 32'(psum_out), 0);
    @(posedge clk); #1;
    start_valid = 0; psum_in_valid = 0;
    rst = 1'b0;

    // Basic run and partial-sum add
    load(1, 2, 3, 1, 2, 3, 4, 5);
    run(8'd0, 8'd14, 8'd20, 8'd26);
    run(8'd10, 8'd24, 8'd30, 8'd36);

    // Out-of-range filter write is accepted and dropped
    write_f(2'd3, 4'd7);
    run(8'd0, 8'd14, 8'd20, 8'd26);

    // Simultaneous writes and start: run sees updated filter[0]=2, ifmap[0]=3
    filter_addr = 2'd0; filter_in = 4'd2; filter_addr_valid = 1; filter_in_valid = 1;
    ifmap_addr = 3'd0; ifmap_in = 4'd3; ifmap_addr_valid = 1; ifmap_in_valid = 1;
    start_valid = 1;
    exp_q.push_back(8'd19); exp_q.push_back(8'd22); exp_q.push_back(8'd29);
    exp_done++;
    @(negedge clk);
    check("sim_filter_ready", 32'(filter_addr_ready && filter_in_ready), 1);
    check("sim_ifmap_ready", 32'(ifmap_addr_ready && ifmap_in_ready), 1);
    check("sim_start_ready", 32'(start_ready), 1);
    @(posedge clk); #1;
    filter_addr_valid = 0; filter_in_valid = 0;
    ifmap_addr_valid = 0; ifmap_in_valid = 0; start_valid = 0;
    send_psum(8'd0); send_psum(8'd0); send_psum(8'd0);
    wait_done();
    write_f(2'd0, 4'd1); write_i(3'd0, 4'd1);

    // Backpressure on the first result
    psum_out_ready = 1'b0;
    exp_q.push_back(8'd14); exp_q.push_back(8'd20); exp_q.push_back(8'd26);
    exp_done++;
    do_start();
    send_psum(8'd0);
    n = 0;
    while (!psum_out_valid && n < 50) begin @(negedge clk); n++; end
    if (!psum_out_valid) timeout_fail("bp_valid");
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", 32'(psum_out_valid), 1);
      check("bp_no_psum_ready", 32'(psum_in_ready), 0);
    end
    @(posedge clk); #1;
    psum_out_ready = 1'b1;
    send_psum(8'd0); send_psum(8'd0);
    wait_done();

    // Overflow
    load(15, 15, 15, 15, 15, 15, 15, 15);
    run(8'd0, ovf, ovf, ovf);

    // Reset in the middle of the second output's MAC
    load(1, 2, 3, 1, 2, 3, 4, 5);
    exp_q.push_back(8'd14);
    do_start();
    send_psum(8'd0);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) timeout_fail("first_out");
    @(posedge clk); #1;
    send_psum(8'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_psum_out_valid", 32'(psum_out_valid), 0);
    check("midrst_start_ready", 32'(start_ready), 0);
    check("midrst_psum_in_ready", 32'(psum_in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_psum_out", 32'(psum_out), 0);
    check("postrst_start_ready", 32'(start_ready), 1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    run(8'd0, 8'd0, 8'd0, 8'd0);
    load(1, 2, 3, 1, 2, 3, 4, 5);
    run(8'd0, 8'd14, 8'd20, 8'd26);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/pe_conv1d.md
# pe_conv1d

Single processing element for 1-D convolution in the CNN accelerator datapath.
- Holds a small filter scratchpad and an ifmap scratchpad, loaded over addressed write channels.
- On a start token, computes every valid sliding-window dot product, each added to an incoming partial sum, and emits them in order as psums.
- Ends each run with a done token.
- Sits between the NoC packet interfaces and the psum accumulation chain.

## Interface
- WIDTH, 8, psum width; filter/ifmap element width is WIDTH/2.
- DEPTH_I, 5, ifmap scratchpad entries.
- ADDR_I, 3, ifmap address width.
- DEPTH_F, 3, filter scratchpad entries (must be ≤ DEPTH_I).
- ADDR_F, 2, filter address width.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- filter_addr_valid / filter_addr_ready  in/out  1  filter address channel.
- filter_addr  in  ADDR_F  filter write address.
- filter_in_valid / filter_in_ready  in/out  1  filter data channel.
- filter_in  in  WIDTH/2  filter weight, unsigned.
- ifmap_addr_valid / ifmap_addr_ready  in/out  1  ifmap address channel.
- ifmap_addr  in  ADDR_I  ifmap write address.
- ifmap_in_valid / ifmap_in_ready  in/out  1  ifmap data channel.
- ifmap_in  in  WIDTH/2  ifmap element, unsigned.
- start_valid / start_ready  in/out  1  run trigger token; carries no data.
- psum_in_valid / psum_in_ready  in/out  1  incoming partial-sum channel.
- psum_in  in  WIDTH  incoming partial sum.
- psum_out_valid / psum_out_ready  out/in  1  result channel.
- psum_out  out  WIDTH  result partial sum.
- done_valid / done_ready  out/in  1  end-of-run token.

## Operation
- Handshake rule: a transfer occurs in any cycle where valid=1 and ready=1.
- Filter write:
  - Address and data readies are both high only when both valids are high in IDLE.
  - On that transfer, filter[filter_addr] <= filter_in.
  - filter_addr ≥ DEPTH_F: write is dropped but the handshake still completes.
- Ifmap write: same pairing rules, writing ifmap[ifmap_addr] <= ifmap_in.
- Number of outputs N = DEPTH_I − DEPTH_F + 1.
- States:
  - IDLE: write and start readies high. A start transfer sets j=0 and moves to PSUM.
  - PSUM: psum_in_ready=1. On transfer, acc <= psum_in, k=0, move to MAC.
  - MAC: each cycle, acc <= acc + filter[k]*ifmap[j+k] and k++. After the k=DEPTH_F−1 update, move to OUT.
  - OUT: psum_out_valid=1 and psum_out=acc, held stable until the transfer. On transfer: if j==N−1 move to DONE, else j++ and return to PSUM.
  - DONE: done_valid=1. On transfer, return to IDLE.
- Arithmetic:
  - Unsigned. Products are WIDTH bits wide.
  - Accumulation wraps modulo 2^WIDTH (see Configuration).
- Scratchpad contents persist across runs; only the filter/ifmap write channels modify them.
- Write channels are not ready outside IDLE; writes are held off until the run completes.

## Timing
- Reset, applied at any point including mid-run:
  - State returns to IDLE, acc=0, j=k=0.
  - Both scratchpads are cleared to 0.
  - All ready and valid outputs are low while rst=1.
  - psum_out resets to 0.
- Simultaneous filter write, ifmap write and start in IDLE: all three are accepted. The writes land on the same edge, so the run uses the updated data.
- Latency:
  - Start transfer at edge t: psum_in_ready is high from cycle t+1.
  - psum_in transfer at edge p: psum_out_valid is high at cycle p+DEPTH_F.
- Backpressure: psum_out and done stay stable while their ready is low. No output is ever dropped or duplicated.
- start_valid outside IDLE is ignored (start_ready is low).

## Configuration
- PE_PSUM_SAT_EN.
  - Defined: every accumulate step saturates at 2^WIDTH−1.
  - Undefined: accumulation wraps modulo 2^WIDTH.

## Test plan
- Basic run: filter {1,2,3}, ifmap {1,2,3,4,5}, psum_in 0 per output → psum_out 14, 20, 26, then one done token.
- Partial-sum add: same data, psum_in 10 each → psum_out 24, 30, 36.
- Overflow: all filter and ifmap entries 15, psum_in 0 → 163 each (wrap) without PE_PSUM_SAT_EN; 255 each with it.
- Backpressure: hold psum_out_ready low 5 cycles on the first result → psum_out_valid stays 1 and psum_out stays 14; the next output follows only after the transfer.
- Reset mid-MAC: assert rst for 1 cycle during the second output's MAC → no further psum_out or done. Scratchpads read 0, so a rerun with psum_in 0 gives 0, 0, 0. After reloading, the basic run again gives 14, 20, 26.
- Out-of-range write: filter_addr 3 with data 7 → handshake completes and the filter contents are unchanged (basic run still 14, 20, 26).
